// File: rtl/fnd_display_ctrl_if.sv
// Bundle between the time source and the FND scan controller: packed time word,
// display select and edit-blink mask in, board anode/segment pins out.
interface fnd_display_ctrl_if;
    logic [23:0] i_time;
    logic        i_disp_sel;
    logic [3:0]  i_blink;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_data;

    modport master (
        output i_time,
        output i_disp_sel,
        output i_blink,
        input  fnd_digit,
        input  fnd_data
    );

    modport slave (
        input  i_time,
        input  i_disp_sel,
        input  i_blink,
        output fnd_digit,
        output fnd_data
    );
endinterface

// File: rtl/fnd_display_ctrl.sv
// Four-digit seven-segment scan controller. Shows sec.msec or hour.min, lights the
// decimal point of digit 2 for the first half of every second, and can blank
// individual digits at BLINK_HZ for edit mode. Both outputs come straight from flops.
module fnd_display_ctrl #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SCAN_FREQ = 1000,
    parameter int BLINK_HZ  = 2
) (
    input  logic                clk,
    input  logic                reset,
    fnd_display_ctrl_if.slave   bus
);

    localparam int SCAN_N   = CLK_FREQ / SCAN_FREQ;
    localparam int BLINK_N  = CLK_FREQ / (2 * BLINK_HZ);
    localparam int SCAN_W   = $clog2(SCAN_N + 1);
    localparam int BLINK_W  = $clog2(BLINK_N + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_N - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_N - 1);

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]         index_q, index_d;
    logic               blink_phase_q, blink_phase_d;
    logic [23:0]        time_q, time_d;
    logic               disp_sel_q, disp_sel_d;
    logic [3:0]         blink_q, blink_d;
    logic [3:0]         fnd_digit_q, fnd_digit_d;
    logic [7:0]         fnd_data_q, fnd_data_d;

    logic               scan_tick;
    logic               blink_wrap;
    logic [4:0]         hour;
    logic [5:0]         minute;
    logic [5:0]         sec;
    logic [6:0]         msec;
    logic [6:0]         field;
    logic [3:0]         digit_val;
    logic [6:0]         segs;
    logic               dp_n;

    // Active-low {g,f,e,d,c,b,a}; anything above 9 (e.g. tens of msec=127) shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;
        endcase
    endfunction

    // Free-running scan and blink timebases plus the stage-1 input capture.
    always_comb begin
        scan_tick     = (scan_cnt_q == SCAN_LAST);
        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + 1'b1;
        index_d       = scan_tick ? index_q + 2'd1 : index_q;
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
        time_d        = bus.i_time;
        disp_sel_d    = bus.i_disp_sel;
        blink_d       = bus.i_blink;
    end

    // Stage 2: pick the field for the scanned digit, split tens/ones, decode and blank.
    always_comb begin
        hour   = time_q[23:19];
        minute = time_q[18:13];
        sec    = time_q[12:7];
        msec   = time_q[6:0];
        if (index_q[1]) begin
            field = disp_sel_q ? {2'b00, hour} : {1'b0, sec};
        end else begin
            field = disp_sel_q ? {1'b0, minute} : msec;
        end
        if (index_q[0]) begin
            digit_val = 4'(field / 7'd10);
        end else begin
            digit_val = 4'(field % 7'd10);
        end
        segs        = seg_decode(digit_val);
        dp_n        = ~((index_q == 2'd2) && (msec < 7'd50));
        fnd_digit_d = ~(4'b0001 << index_q);
        if (blink_q[index_q] && blink_phase_q) begin
            fnd_data_d = 8'hFF;
        end else begin
            fnd_data_d = {dp_n, segs};
        end
    end

    // All state, with outputs blanked and scanning parked at digit 0 during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            index_q       <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            time_q        <= 24'd0;
            disp_sel_q    <= 1'b0;
            blink_q       <= 4'd0;
            fnd_digit_q   <= 4'b1111;
            fnd_data_q    <= 8'hFF;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            index_q       <= index_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            time_q        <= time_d;
            disp_sel_q    <= disp_sel_d;
            blink_q       <= blink_d;
            fnd_digit_q   <= fnd_digit_d;
            fnd_data_q    <= fnd_data_d;
        end
    end

    assign bus.fnd_digit = fnd_digit_q;
    assign bus.fnd_data  = fnd_data_q;

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// Bench for fnd_display_ctrl: directed scans with hand-derived segment values,
// then randomized traffic against a cycle-count based reference model.
module tb_fnd_display_ctrl;

    localparam int CLK_FREQ  = 1000;
    localparam int SCAN_FREQ = 100;
    localparam int BLINK_HZ  = 25;
    localparam int SCAN_N    = CLK_FREQ / SCAN_FREQ;
    localparam int BLINK_N   = CLK_FREQ / (2 * BLINK_HZ);

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF
    };
    localparam logic [3:0] DIGIT_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic clk;
    logic reset;

    fnd_display_ctrl_if bus ();

    fnd_display_ctrl #(
        .CLK_FREQ  (CLK_FREQ),
        .SCAN_FREQ (SCAN_FREQ),
        .BLINK_HZ  (BLINK_HZ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total_checks;
    int bad_checks;

    // Reference model state: edges since reset released and last captured inputs.
    int          model_t;
    logic [23:0] prev_time;
    logic        prev_sel;
    logic [3:0]  prev_blink;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] packTime(input int h, input int m, input int s, input int ms);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic [6:0] ff;
        hh = 5'(h);
        mm = 6'(m);
        ss = 6'(s);
        ff = 7'(ms);
        return {hh, mm, ss, ff};
    endfunction

    // Expected {fnd_digit, fnd_data} for the t-th edge after reset release.
    function automatic logic [11:0] modelOutput(input int t, input logic [23:0] tm,
                                                input logic sel, input logic [3:0] blk);
        int idx;
        int phase;
        int hour;
        int minute;
        int sec;
        int msec;
        int value;
        int dval;
        logic [7:0] data;
        idx    = ((t - 1) / SCAN_N) % 4;
        phase  = ((t - 1) / BLINK_N) % 2;
        hour   = int'(tm[23:19]);
        minute = int'(tm[18:13]);
        sec    = int'(tm[12:7]);
        msec   = int'(tm[6:0]);
        if (idx < 2) value = sel ? minute : msec;
        else         value = sel ? hour : sec;
        dval = (idx % 2 == 0) ? (value % 10) : (value / 10);
        data = SEG_TAB[dval];
        if (idx == 2 && msec < 50) data[7] = 1'b0;
        if (blk[idx] && phase == 1) data = 8'hFF;
        return {DIGIT_TAB[idx], data};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0d, time %0t)", tag, observed, expected, model_t, $time);
        end
    endtask

    // Drive one cycle of inputs, sample after the edge and compare against the model.
    task automatic applyStimulus(input logic rst, input logic [23:0] tm, input logic sel, input logic [3:0] blk);
        logic [11:0] exp_out;
        reset          = rst;
        bus.i_time     = tm;
        bus.i_disp_sel = sel;
        bus.i_blink    = blk;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_out    = {4'b1111, 8'hFF};
            model_t    = 0;
        end else begin
            model_t    = model_t + 1;
            exp_out    = modelOutput(model_t, prev_time, prev_sel, prev_blink);
        end
        checkOutput("digit", 32'(bus.fnd_digit), 32'(exp_out[11:8]));
        checkOutput("data", 32'(bus.fnd_data), 32'(exp_out[7:0]));
        if (rst) begin
            prev_time  = 24'd0;
            prev_sel   = 1'b0;
            prev_blink = 4'd0;
        end else begin
            prev_time  = tm;
            prev_sel   = sel;
            prev_blink = blk;
        end
    endtask

    // One reset then a full scan with constant inputs; digit k checked at t = 2 + 10k.
    task automatic runScan(input string tag, input logic [23:0] tm, input logic sel, input logic [3:0] blk,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_data [4];
        exp_data = '{e0, e1, e2, e3};
        applyStimulus(1'b1, tm, sel, blk);
        for (int i = 0; i < 4 * SCAN_N; i++) begin
            applyStimulus(1'b0, tm, sel, blk);
            if ((model_t - 2) % SCAN_N == 0) begin
                checkOutput({tag, "_digit"}, 32'(bus.fnd_digit), 32'(DIGIT_TAB[(model_t - 2) / SCAN_N]));
                checkOutput({tag, "_data"}, 32'(bus.fnd_data), 32'(exp_data[(model_t - 2) / SCAN_N]));
            end
        end
    endtask

    initial begin
        logic [23:0] cur_time;
        logic        cur_sel;
        logic [3:0]  cur_blink;
        logic [31:0] r;

        total_checks = 0;
        bad_checks   = 0;
        model_t      = 0;
        prev_time    = 24'd0;
        prev_sel     = 1'b0;
        prev_blink   = 4'd0;

        // Reset held for 3 cycles, then index 0 with value 0 and advance after 10 cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 24'd0, 1'b0, 4'd0);
            checkOutput("rst_data", 32'(bus.fnd_data), 32'hFF);
        end
        applyStimulus(1'b0, 24'd0, 1'b0, 4'd0);
        checkOutput("first_digit", 32'(bus.fnd_digit), 32'b1110);
        checkOutput("first_data", 32'(bus.fnd_data), 32'hC0);
        for (int i = 0; i < SCAN_N; i++) applyStimulus(1'b0, 24'd0, 1'b0, 4'd0);
        checkOutput("adv_digit", 32'(bus.fnd_digit), 32'b1101);

        runScan("secmsec", packTime(0, 0, 12, 34), 1'b0, 4'b0000, 8'h99, 8'hB0, 8'h24, 8'hF9);
        runScan("hourmin", packTime(23, 59, 0, 75), 1'b1, 4'b0000, 8'h90, 8'h92, 8'hB0, 8'hA4);
        runScan("range", packTime(0, 0, 0, 127), 1'b0, 4'b0000, 8'hF8, 8'hBF, 8'hC0, 8'hC0);
        runScan("blink", packTime(0, 0, 12, 34), 1'b0, 4'b1111, 8'h99, 8'hB0, 8'hFF, 8'hFF);

        // Mid-digit time change shows two edges later; reset during digit 2 blanks at once.
        applyStimulus(1'b1, packTime(0, 0, 12, 34), 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, packTime(0, 0, 12, 34), 1'b0, 4'd0);
        applyStimulus(1'b0, packTime(0, 0, 12, 56), 1'b0, 4'd0);
        checkOutput("lat_old", 32'(bus.fnd_data), 32'h99);
        applyStimulus(1'b0, packTime(0, 0, 12, 56), 1'b0, 4'd0);
        checkOutput("lat_new", 32'(bus.fnd_data), 32'h82);
        while (model_t < 24) applyStimulus(1'b0, packTime(0, 0, 12, 56), 1'b0, 4'd0);
        checkOutput("pre_rst_digit", 32'(bus.fnd_digit), 32'b1011);
        applyStimulus(1'b1, packTime(0, 0, 12, 56), 1'b0, 4'd0);
        checkOutput("midrst_digit", 32'(bus.fnd_digit), 32'b1111);
        checkOutput("midrst_data", 32'(bus.fnd_data), 32'hFF);
        applyStimulus(1'b0, packTime(0, 0, 12, 56), 1'b0, 4'd0);
        checkOutput("restart_digit", 32'(bus.fnd_digit), 32'b1110);

        // Randomized traffic: legal and out-of-range times, mode flips, blink masks, resets.
        cur_time  = packTime(1, 2, 3, 4);
        cur_sel   = 1'b0;
        cur_blink = 4'd0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    cur_time = packTime($urandom_range(0, 23), $urandom_range(0, 59),
                                        $urandom_range(0, 59), $urandom_range(0, 99));
                end else begin
                    r        = $urandom;
                    cur_time = r[23:0];
                end
            end
            if ($urandom_range(0, 19) == 0) cur_sel = ~cur_sel;
            if ($urandom_range(0, 29) == 0) begin
                r         = $urandom;
                cur_blink = r[3:0];
            end
            applyStimulus($urandom_range(0, 299) == 0, cur_time, cur_sel, cur_blink);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/fnd_display_ctrl.md
# fnd_display_ctrl

Four-digit seven-segment scan controller that sits directly downstream of the stopwatch/watch top. It consumes the packed 24-bit time word `out_data` and drives the board FND pins (`fnd_digit`, `fnd_data`). The controller shows either sec.msec or hour.min, and blinks a decimal point at 1 Hz from the msec field. It also supports per-digit blanking-blink for edit mode.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_FREQ, 1000, digit-advance rate in Hz; scan period = CLK_FREQ/SCAN_FREQ cycles.
- BLINK_HZ, 2, edit-blink rate; the blink phase toggles every CLK_FREQ/(2*BLINK_HZ) cycles.

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- i_time  input  24  packed time: hour[23:19], min[18:13], sec[12:7], msec[6:0].
- i_disp_sel  input  1  0 shows sec:msec; 1 shows hour:min.
- i_blink  input  4  per-digit blink enable, where bit n maps to digit index n.
- fnd_digit  output  4  digit anode select, active-low one-hot.
- fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Scan tick counter counts 0..CLK_FREQ/SCAN_FREQ-1. On the terminal count it pulses a one-cycle scan tick and wraps to 0.
- 2-bit digit index advances on each scan tick: 0→1→2→3→0. Index 0 is the rightmost digit and maps to `fnd_digit[0]`.
- Blink counter counts 0..CLK_FREQ/(2*BLINK_HZ)-1. At the terminal count it wraps and toggles `blink_phase`.
- Stage 1 registers `i_time` and `i_disp_sel` every cycle.
- Stage 2 selects the field for the current index, splits it into tens and ones (value/10, value%10), decodes it, and registers it to the outputs.
- Digit mapping when `sel`=0:
  - index 0 = msec%10, index 1 = msec/10
  - index 2 = sec%10, index 3 = sec/10
- Digit mapping when `sel`=1:
  - index 0 = min%10, index 1 = min/10
  - index 2 = hour%10, index 3 = hour/10
- Decode table, bits[6:0]: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any digit value 10–15 decodes to dash (BF). This covers out-of-range inputs such as msec=127, which gives tens digit 12.
- Decimal point (bit7):
  - Driven 0 (lit) only on index 2, and only while the registered msec < 50, in both display modes.
  - Otherwise bit7 = 1.
  - Result: a 1 Hz dp blink when msec runs at 100 Hz.
- Edit blink: when `i_blink[index]`=1 and `blink_phase`=1, `fnd_data` = FF for that index. `fnd_digit` still selects the digit.
- Digit select: `fnd_digit` = ~(4'b0001 << index), registered in the same cycle as `fnd_data`.

## Timing
- Reset values: `fnd_digit`=4'b1111 (all off), `fnd_data`=8'hFF. Scan counter, digit index, blink counter and `blink_phase` all reset to 0, as do the stage-1 registers.
- First cycle after reset deasserts: outputs show index 0 (`fnd_digit`=4'b1110) with decoded `i_time` of value 0, i.e. C0 for sec/msec = 0.
- Input-to-output latency: a change on `i_time`, `i_disp_sel` or `i_blink` appears on `fnd_data` 2 cycles later for the currently scanned digit. `i_blink` passes through stage 1 with the same latency.
- Index change: `fnd_digit` and `fnd_data` change together, 1 cycle after the scan tick. No cycle may show a new digit select with old segments, or the reverse.
- Scan period: each digit is held exactly CLK_FREQ/SCAN_FREQ cycles.
- Blink phase: toggles exactly every CLK_FREQ/(2*BLINK_HZ) cycles. It is independent of the scan tick, and both may fire in the same cycle without interaction.
- Reset mid-scan: all outputs and counters take their reset values on the next edge. Scanning restarts at index 0.
- Outputs are glitch-free: both are driven directly from flops.

## Test plan
Simulation parameters: CLK_FREQ=1000, SCAN_FREQ=100 (10-cycle scan), BLINK_HZ=25 (20-cycle phase).
- Reset: hold reset for 3 cycles → `fnd_digit`=1111 and `fnd_data`=FF throughout. After release, `fnd_digit`=1110 and the index advances every 10 cycles.
- sec:msec mode: `sel`=0, sec=12, msec=34 → one full scan shows:
  - index 0 = 99, index 1 = B0
  - index 2 = 24 (A4 with dp lit), index 3 = F9
  - `fnd_digit` sequence 1110, 1101, 1011, 0111.
- hour:min mode: `sel`=1, hour=23, min=59, msec=75 → index 0 = 90, index 1 = 92, index 2 = B0 (dp off), index 3 = A4.
- Edit blink: `i_blink`=0011, `sel`=0 → indices 0 and 1 read FF in alternate 20-cycle windows while `fnd_digit` still selects them. Indices 2 and 3 are never blanked.
- Out of range: msec=127, `sel`=0 → index 1 = BF (dash), index 0 = F8 (7).
- Latency and reset: change `i_time` mid-digit → new segments appear exactly 2 cycles later. Assert reset during index 2 → next edge gives 1111/FF.
